// File: rtl/serial_alu_seq_pkg.sv
// Shared encodings for the bit-serial ALU sequencer.
// Contents: ALU op codes and the sequencer FSM state type.
// No logic; imported by serial_bit_op and serial_alu_seq.
package serial_alu_seq_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SLT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/serial_alu_seq_bit_op.sv
// Single-bit ALU slice: AND / OR / full-add of one (already inverted) bit pair.
// Latency: purely combinational. Backpressure: none.
// Ports: ak/bk effective operand bits, carry in, op -> res bit, carry_next.
module serial_bit_op
  import serial_alu_seq_pkg::*;
(
  input  logic       ak,
  input  logic       bk,
  input  logic       carry,
  input  logic [1:0] op,
  output logic       res,
  output logic       carry_next
);

  always_comb begin
    res        = 1'b0;
    carry_next = 1'b0;  // logic ops keep the carry chain parked at 0
    case (op)
      OP_AND:  res = ak & bk;
      OP_OR:   res = ak | bk;
      default: begin  // ADD and SLT both run a full adder
        res        = ak ^ bk ^ carry;
        carry_next = (ak & bk) | (ak & carry) | (bk & carry);
      end
    endcase
  end

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial WIDTH-bit ALU sequencer: one bit pair per clock, LSB first, registered carry.
// Latency: out_valid rises exactly WIDTH clocks after the accept edge.
// Backpressure: in_ready only in IDLE; result/flags held in DONE until out_ready.
// Ports: clk, rst_n; in_valid/in_ready with a, b, op, ainvert, binvert;
//        out_valid/out_ready with result, zero, cout, ovf.
module serial_alu_seq
  import serial_alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             ainvert,
  input  logic             binvert,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             ovf
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic [1:0]       op_r;
  logic             ainv_r, binv_r;

  logic             ak_eff, bk_eff, bit_res, carry_nxt, less;
  logic [WIDTH-1:0] res_shifted, final_res;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  // SLT is always A - B regardless of the invert controls.
  always_comb begin
    ak_eff = a_sh[0] ^ ainv_r;
    bk_eff = b_sh[0] ^ binv_r;
    if (op_r == OP_SLT) begin
      ak_eff = a_sh[0];
      bk_eff = ~b_sh[0];
    end
  end

  serial_bit_op u_bit_op (
    .ak         (ak_eff),
    .bk         (bk_eff),
    .carry      (carry),
    .op         (op_r),
    .res        (bit_res),
    .carry_next (carry_nxt)
  );

  // New bit enters at the MSB; after WIDTH shifts bit 0 lands at [0].
  assign res_shifted = {bit_res, res_sh[WIDTH-1:1]};
  // Sign of the true difference: MSB of the sum corrected by MSB overflow.
  assign less        = bit_res ^ (carry ^ carry_nxt);
  assign final_res   = (op_r == OP_SLT) ? {{(WIDTH-1){1'b0}}, less} : res_shifted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid)      state_nxt = ST_RUN;
      ST_RUN:  if (cnt == LAST)   state_nxt = ST_DONE;
      ST_DONE: if (out_ready)     state_nxt = ST_IDLE;
      default:                    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      carry  <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      op_r   <= OP_AND;
      ainv_r <= 1'b0;
      binv_r <= 1'b0;
      result <= '0;
      zero   <= 1'b0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (in_valid && in_ready) begin
      a_sh   <= a;
      b_sh   <= b;
      res_sh <= '0;
      op_r   <= op;
      ainv_r <= ainvert;
      binv_r <= binvert;
      cnt    <= '0;
      carry  <= (op == OP_SLT) || ((op == OP_ADD) && binvert);
    end else if (state == ST_RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_shifted;
      carry  <= carry_nxt;
      if (cnt == LAST) begin
        // Output registers only change here, so they stay put through DONE and IDLE.
        result <= final_res;
        zero   <= (final_res == '0);
        cout   <= op_r[1] & carry_nxt;
        ovf    <= (op_r == OP_ADD) & (carry ^ carry_nxt);
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_alu_seq.sv
module tb_serial_alu_seq;
  import serial_alu_seq_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0, b = '0;
  logic [1:0]   op = 2'b00;
  logic         ainvert = 1'b0, binvert = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero, cout, ovf;

  serial_alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .ainvert(ainvert), .binvert(binvert),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] r;
    logic         z, c, v;
    int           acc;   // cycle number of the accept edge
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   rdy_mode = 0;  // 0 random, 1 held low, 2 held high

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: whole-word arithmetic straight from the operation definitions.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic [1:0] opv, input logic ai, input logic bi);
    exp_t         e;
    logic [W-1:0] x, y;
    logic [W:0]   wide;
    int           s;
    x = ai ? ~av : av;
    y = bi ? ~bv : bv;
    e.r = '0; e.c = 1'b0; e.v = 1'b0; e.acc = 0;
    case (opv)
      OP_AND: e.r = x & y;
      OP_OR:  e.r = x | y;
      OP_ADD: begin
        wide = {1'b0, x} + {1'b0, y} + (W+1)'(bi);
        e.r  = wide[W-1:0];
        e.c  = wide[W];
        s    = int'($signed(x)) + int'($signed(y)) + int'(bi);
        e.v  = (s > (2**(W-1) - 1)) || (s < -(2**(W-1)));
      end
      default: begin
        e.r = ($signed(av) < $signed(bv)) ? W'(1) : W'(0);
        e.c = (av >= bv);  // no borrow from A - B
      end
    endcase
    e.z = (e.r == '0);
    return e;
  endfunction

  always @(negedge clk) begin
    case (rdy_mode)
      1:       out_ready = 1'b0;
      2:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: compares every cycle the DUT presents a result, pops on handshake.
  bit seen = 1'b0;
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      seen = 1'b0;
    end else if (out_valid) begin
      if (sbq.size() == 0) begin
        check("spurious_out_valid", {31'b0, out_valid}, 32'd0);
      end else begin
        if (!seen) begin
          check("latency", cyc - sbq[0].acc, W);
          seen = 1'b1;
        end
        check("result", result, sbq[0].r);
        check("zero", {31'b0, zero}, {31'b0, sbq[0].z});
        check("cout", {31'b0, cout}, {31'b0, sbq[0].c});
        check("ovf", {31'b0, ovf}, {31'b0, sbq[0].v});
        check("in_ready_in_done", {31'b0, in_ready}, 32'd0);
        if (out_ready) begin
          void'(sbq.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) check("accept_timeout", {31'b0, in_ready}, 32'd1);
  endtask

  task automatic junk_inputs();
    a       = W'($urandom);
    b       = W'($urandom);
    op      = 2'($urandom_range(0, 3));
    ainvert = 1'($urandom_range(0, 1));
    binvert = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic [1:0] opv, input logic ai, input logic bi);
    exp_t e;
    wait_ready();
    if (in_ready !== 1'b1) return;
    in_valid = 1'b1; a = av; b = bv; op = opv; ainvert = ai; binvert = bi;
    e = model(av, bv, opv, ai, bi);
    e.acc = cyc + 1;
    sbq.push_back(e);
    @(negedge clk);
    // Garbage on the inputs while RUN must not disturb the result.
    for (int i = 0; i < W - 3; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      junk_inputs();
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) check("drain_timeout", sbq.size(), 32'd0);
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = '0;
      1:       v = {1'b0, {(W-1){1'b1}}};
      2:       v = {1'b1, {(W-1){1'b0}}};
      3:       v = '1;
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_flags", {29'b0, zero, cout, ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    rdy_mode = 2;
    send(8'h3C, 8'h05, OP_ADD, 1'b0, 1'b0);
    send(8'h05, 8'h05, OP_ADD, 1'b0, 1'b1);
    send(8'h7F, 8'h01, OP_ADD, 1'b0, 1'b0);
    send(8'h80, 8'h01, OP_SLT, 1'b0, 1'b0);
    send(8'h7F, 8'h80, OP_SLT, 1'b1, 1'b1);
    send(8'h0F, 8'h03, OP_AND, 1'b1, 1'b1);
    send(8'hA0, 8'h05, OP_OR,  1'b0, 1'b0);
    wait_drain();

    // Stall in DONE while wiggling inputs; the monitor checks the hold each cycle.
    rdy_mode = 1;
    send(8'h7F, 8'h01, OP_ADD, 1'b0, 1'b0);
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("stall_reach_done", {31'b0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      junk_inputs();
      #2;
      check("stall_in_ready", {31'b0, in_ready}, 32'd0);
      check("stall_out_valid", {31'b0, out_valid}, 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rdy_mode = 2;
    n = 0;
    while (out_valid === 1'b1 && n < 5) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("handoff_in_ready", {31'b0, in_ready}, 32'd1);
    check("handoff_out_valid", {31'b0, out_valid}, 32'd0);
    wait_drain();

    // Async reset mid-RUN with counter at 3; prior result leaves nonzero state to clear.
    send(8'hFF, 8'h01, OP_ADD, 1'b0, 1'b0);
    wait_drain();
    send(8'h7F, 8'h01, OP_ADD, 1'b0, 1'b0);
    wait_drain();
    wait_ready();
    in_valid = 1'b1; a = 8'h12; b = 8'h34; op = OP_ADD; ainvert = 1'b0; binvert = 1'b0;
    @(negedge clk);   // counter 0
    in_valid = 1'b0;
    repeat (3) @(negedge clk);  // counter 3
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'b0, out_valid}, 32'd0);
    check("arst_result", result, 32'd0);
    check("arst_flags", {29'b0, zero, cout, ovf}, 32'd0);
    check("arst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    send(8'hC8, 8'h38, OP_ADD, 1'b0, 1'b0);
    wait_drain();

    rdy_mode = 0;
    for (int t = 0; t < 300; t++) begin
      send(pick(), pick(), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_alu_seq.md
Name: serial_alu_seq

Overview:
Bit-serial N-bit ALU sequencer placed directly upstream of, and consuming, the single-bit ALU datapath. It accepts two WIDTH-bit operands plus an operation code through a valid/ready handshake. It then processes one bit pair per clock, LSB first, with a registered carry chain, and returns the WIDTH-bit result with zero, carry-out and overflow flags through a second valid/ready handshake. Its purpose is to trade latency for area wherever a full-width ripple ALU is not justified.

Parameters:
WIDTH, 8, operand/result width in bits (≥2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand/op bundle valid
in_ready  out  1  sequencer can accept a bundle
a  in  WIDTH  operand A
b  in  WIDTH  operand B
op  in  2  00 AND, 01 OR, 10 ADD, 11 SLT
ainvert  in  1  invert A bits before the op (ops 00/01/10)
binvert  in  1  invert B bits before the op; for op 10 also sets initial carry = 1 (subtract)
out_valid  out  1  result bundle valid
out_ready  in  1  downstream accepts the result
result  out  WIDTH  operation result
zero  out  1  result == 0
cout  out  1  final carry-out (ops 10/11), else 0
ovf  out  1  signed overflow (op 10), else 0

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low (clk, rst_n). The polarity and synchronicity are fixed.
- FSM states: IDLE, RUN, DONE.
- Reset (asserted at any time, including mid-RUN): state → IDLE, bit counter → 0, carry → 0, all shift registers → 0. Outputs: result = 0, zero = 0, cout = 0, ovf = 0, out_valid = 0, in_ready = 1. Any in-flight operation is dropped.
- in_ready = (state == IDLE). out_valid = (state == DONE).
- Accept: on the edge where in_valid & in_ready, latch a, b, op, ainvert, binvert, then set the counter to 0 and go to RUN.
  - Initial carry: 1 if op = 11, or if op = 10 and binvert = 1; otherwise 0.
- RUN, per cycle at bit k = counter:
  - op 00/01/10: a_k' = a_k ^ ainvert, b_k' = b_k ^ binvert.
  - op 11: ainvert/binvert ignored; a_k' = a_k, b_k' = ~b_k (always A − B).
  - Bit result: AND/OR of a_k', b_k' for ops 00/01; sum = a_k' ^ b_k' ^ carry for ops 10/11.
  - Carry register updates to the majority of (a_k', b_k', carry) for ops 10/11. It holds at 0 for ops 00/01.
  - The bit result shifts into the result register from the MSB side, so after WIDTH shifts bit 0 sits at result[0].
  - At k = WIDTH−1: capture cout = carry-out of the MSB and ovf = carry-into-MSB ^ carry-out-of-MSB (op 10 only). Go to DONE.
- SLT finalisation on the RUN→DONE edge: less = sum_MSB ^ (carry-in_MSB ^ carry-out_MSB). result = {WIDTH−1 zeros, less}. cout is the subtraction carry; ovf = 0.
- zero is registered on the RUN→DONE edge from the final result value, including for SLT.
- Latency: out_valid rises exactly WIDTH cycles after the accept edge.
- DONE:
  - result and all flags are held stable while out_valid & ~out_ready.
  - On out_ready, go to IDLE. in_ready is 1 on the next cycle; there is no same-cycle re-accept.
  - Flags and result stay at their last values in IDLE until the next DONE.
- In RUN and DONE, in_valid and the a/b/op inputs are ignored; changing them has no effect on the result.
- Width rules: the counter is clog2(WIDTH) bits wide, with no wrap beyond WIDTH−1. All arithmetic is modulo 2^WIDTH.

Decomposition:
- Shared package: op encodings (OP_AND = 2'b00, OP_OR = 2'b01, OP_ADD = 2'b10, OP_SLT = 2'b11) and the FSM state encoding.
- One combinational sub-module, serial_bit_op: inputs a_k', b_k', carry, op; outputs bit result and carry_next.
- The FSM, counter, shift registers and flag logic live in serial_alu_seq.

Test Plan (WIDTH = 8):
1. op = 10, a = 0x3C, b = 0x05, inverts 0 → result 0x41, cout 0, ovf 0, zero 0; out_valid high exactly 8 cycles after the accept edge.
2. op = 10, binvert = 1, a = 0x05, b = 0x05 → result 0x00, zero 1, cout 1, ovf 0. Also: op = 10, a = 0x7F, b = 0x01 → result 0x80, ovf 1, cout 0.
3. op = 11, a = 0x80, b = 0x01 → result 0x01. op = 11, a = 0x7F, b = 0x80 → result 0x00, zero 1 (overflow-corrected compare).
4. op = 00, ainvert = 1, binvert = 1, a = 0x0F, b = 0x03 → result 0xF0 (NOR). op = 01, a = 0xA0, b = 0x05 → result 0xA5, cout 0.
5. Hold out_ready = 0 for 5 cycles in DONE while toggling in_valid/a/b → result and flags unchanged, in_ready 0. Release → one-cycle handoff, then in_ready 1.
6. Assert rst_n = 0 asynchronously while counter = 3 in RUN → out_valid 0, result 0, flags 0 immediately; in_ready 1 after release; the next transaction completes correctly.
